wishbone_arbiter: RTL and testbench
===================================

WISHBONE_ARBITER -- requirements
Module: wishbone_arbiter

Interface
REQ-001 The block SHALL have parameter ADR_WIDTH, default 8, address width.
REQ-002 The block SHALL have parameter DAT_WIDTH, default 8, data width.
REQ-003 The block SHALL have parameter SEL_WIDTH, default 8, byte-select width.
REQ-004 The block SHALL have parameter TIMEOUT_CYCLES, default 16, watchdog limit (used only with WB_ARB_TIMEOUT_EN).
REQ-005 The block SHALL have port clk, input, 1, the single clock.
REQ-006 The block SHALL have port rst, input, 1, reset; asynchronous, active-low.
REQ-007 For N=0,1, the block SHALL have ports mN_adr in ADR_WIDTH, mN_datwr in DAT_WIDTH, mN_we in 1, mN_stb in 1, mN_cyc in 1, mN_sel in SEL_WIDTH: master N request side.
REQ-008 For N=0,1, the block SHALL have ports mN_datrd out DAT_WIDTH and mN_ack out 1: master N response side.
REQ-009 The block SHALL have slave-side ports s_adr, s_datwr, s_we, s_stb, s_cyc, s_sel as outputs, and s_datrd, s_ack as inputs, with widths as for masters.
REQ-010 The block SHALL have port gnt, output, 2, one-hot current grant (bit N = master N owns slave).
REQ-011 The block SHALL have port timeout, output, 1, single-cycle watchdog pulse.

Function
REQ-012 The arbiter SHALL be an FSM with states IDLE, GNT0, GNT1, registered on clk.
REQ-013 From IDLE, when exactly one mN_cyc=1, the FSM SHALL move to GNTN at the next edge.
REQ-014 From IDLE with both mN_cyc=1, the FSM SHALL grant the master not granted last (round-robin pointer); after reset the pointer SHALL favour m0.
REQ-015 In GNTN, the grant SHALL be held while mN_cyc=1 regardless of the other master; there SHALL be no preemption.
REQ-016 In GNTN, when mN_cyc=0: if the other master's cyc=1, go directly to its grant state; else go to IDLE. In both cases the pointer SHALL be updated to N.
REQ-017 In GNTN, s_adr/s_datwr/s_we/s_stb/s_sel/s_cyc SHALL combinationally follow master N; mN_ack SHALL equal s_ack.
REQ-018 In IDLE, s_cyc, s_stb, s_we SHALL be 0; s_adr, s_datwr, s_sel SHALL be 0.
REQ-019 A non-granted master's ack SHALL be 0; s_datrd SHALL be broadcast to both mN_datrd.
REQ-020 Latency SHALL be one cycle from mN_cyc rising in IDLE to s_cyc rising; zero added cycles on stb->ack within a granted cycle.
REQ-021 gnt SHALL be 2'b00 in IDLE, 2'b01 in GNT0, 2'b10 in GNT1; never 2'b11.
REQ-022 Without WB_ARB_TIMEOUT_EN, timeout SHALL be constant 0.

Reset
REQ-023 On rst=0, the block SHALL asynchronously enter IDLE, set pointer to favour m0, clear the watchdog count, and drive gnt=0, timeout=0, s_cyc=0, s_stb=0, m0_ack=0, m1_ack=0.
REQ-024 Reset asserted mid-transfer SHALL abort it; no ack SHALL be generated for the aborted access.

Configuration
REQ-025 With macro WB_ARB_TIMEOUT_EN defined, a counter SHALL increment each cycle s_stb=1 and s_ack=0, clear on s_ack=1 or on leaving GNTN.
REQ-026 With WB_ARB_TIMEOUT_EN, when the count reaches TIMEOUT_CYCLES, the block SHALL pulse timeout and mN_ack for one cycle with mN_datrd all-ones, force s_cyc=0 that cycle, and return to IDLE.
REQ-027 Without WB_ARB_TIMEOUT_EN, no counter SHALL exist and a hung slave SHALL hold the grant indefinitely.

Structure
REQ-028 The state typedef arb_state_t (IDLE, GNT0, GNT1) SHALL live in wishbone_pkg.
REQ-029 The watchdog SHALL be sub-module wb_arb_timeout, instantiated only under WB_ARB_TIMEOUT_EN.

Verification
REQ-030 Single master: m0 cyc/stb, adr=0x12, we=0, slave acks with datrd=0xA5 -> gnt=01 one cycle after cyc, m0_datrd=0xA5 with m0_ack, m1_ack=0.
REQ-031 Simultaneous request after reset: m0 and m1 cyc=1 same cycle -> m0 granted first; on m0 cyc drop, gnt goes 01->10 at the next edge with no IDLE cycle.
REQ-032 Fairness: both request continuously, each dropping cyc after one ack -> grants alternate 01,10,01,10 over 4 transactions.
REQ-033 No preemption: m0 holds cyc for 3 transfers while m1 requests -> gnt stays 01 until m0 cyc=0; m1 never sees ack earlier.
REQ-034 Reset mid-cycle: rst=0 while gnt=10 and stb=1 -> gnt=00, s_cyc=0, m1_ack=0 immediately, without waiting for clk.
REQ-035 With WB_ARB_TIMEOUT_EN, TIMEOUT_CYCLES=4, slave never acks -> after 4 stalled cycles timeout=1 and m0_ack=1 with m0_datrd=0xFF for one cycle, then gnt=00.

Source files
------------

// File: rtl/wishbone_pkg.sv
// Shared types for the two-master Wishbone arbiter.
package wishbone_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GNT0 = 2'd1,
    GNT1 = 2'd2
  } arb_state_t;

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_M0   = 2'b01;
  localparam logic [1:0] GNT_M1   = 2'b10;

endpackage

// File: rtl/wb_arb_timeout.sv
// Stall watchdog: counts cycles the granted master strobes without a slave ack.
module wb_arb_timeout #(
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic i_clk,
  input  logic i_rst_n,
  input  logic i_active,
  input  logic i_stb,
  input  logic i_ack,
  output logic o_expire
);

  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);

  logic [CW-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (!i_active || i_ack || o_expire) begin
      r_cnt <= '0;
    end else if (i_stb) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign o_expire = i_active && (r_cnt == CW'(TIMEOUT_CYCLES));

endmodule

// File: rtl/wishbone_arbiter.sv
// Two-master round-robin Wishbone arbiter, non-preemptive.
// Optional stall watchdog enabled by defining WB_ARB_TIMEOUT_EN.
module wishbone_arbiter
  import wishbone_pkg::*;
#(
  parameter int ADR_WIDTH      = 8,
  parameter int DAT_WIDTH      = 8,
  parameter int SEL_WIDTH      = 8,
  parameter int TIMEOUT_CYCLES = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [ADR_WIDTH-1:0] m0_adr,
  input  logic [DAT_WIDTH-1:0] m0_datwr,
  input  logic                 m0_we,
  input  logic                 m0_stb,
  input  logic                 m0_cyc,
  input  logic [SEL_WIDTH-1:0] m0_sel,
  output logic [DAT_WIDTH-1:0] m0_datrd,
  output logic                 m0_ack,
  input  logic [ADR_WIDTH-1:0] m1_adr,
  input  logic [DAT_WIDTH-1:0] m1_datwr,
  input  logic                 m1_we,
  input  logic                 m1_stb,
  input  logic                 m1_cyc,
  input  logic [SEL_WIDTH-1:0] m1_sel,
  output logic [DAT_WIDTH-1:0] m1_datrd,
  output logic                 m1_ack,
  output logic [ADR_WIDTH-1:0] s_adr,
  output logic [DAT_WIDTH-1:0] s_datwr,
  output logic                 s_we,
  output logic                 s_stb,
  output logic                 s_cyc,
  output logic [SEL_WIDTH-1:0] s_sel,
  input  logic [DAT_WIDTH-1:0] s_datrd,
  input  logic                 s_ack,
  output logic [1:0]           gnt,
  output logic                 timeout
);

  arb_state_t r_state;
  arb_state_t w_next;
  logic       r_last_m1;
  logic       w_expire;

`ifdef WB_ARB_TIMEOUT_EN
  wb_arb_timeout #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_wdt (
    .i_clk   (clk),
    .i_rst_n (rst),
    .i_active(r_state != IDLE),
    .i_stb   (s_stb),
    .i_ack   (s_ack),
    .o_expire(w_expire)
  );
`else
  if (TIMEOUT_CYCLES < 1) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be at least 1");
  end
  assign w_expire = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Round-robin pointer: remembers which master finished last, so reset favours m0.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_last_m1 <= 1'b1;
    end else if (r_state == GNT0 && (!m0_cyc || w_expire)) begin
      r_last_m1 <= 1'b0;
    end else if (r_state == GNT1 && (!m1_cyc || w_expire)) begin
      r_last_m1 <= 1'b1;
    end
  end

  always_comb begin
    w_next   = r_state;
    s_adr    = '0;
    s_datwr  = '0;
    s_we     = 1'b0;
    s_stb    = 1'b0;
    s_cyc    = 1'b0;
    s_sel    = '0;
    m0_ack   = 1'b0;
    m1_ack   = 1'b0;
    m0_datrd = s_datrd;
    m1_datrd = s_datrd;
    gnt      = GNT_NONE;
    timeout  = w_expire;
    case (r_state)
      IDLE: begin
        if (m0_cyc && m1_cyc) begin
          w_next = r_last_m1 ? GNT0 : GNT1;
        end else if (m0_cyc) begin
          w_next = GNT0;
        end else if (m1_cyc) begin
          w_next = GNT1;
        end
      end
      GNT0: begin
        gnt = GNT_M0;
        if (w_expire) begin
          // Terminate the hung access with an error-looking ack and drop the bus.
          m0_ack   = 1'b1;
          m0_datrd = '1;
          w_next   = IDLE;
        end else begin
          s_adr   = m0_adr;
          s_datwr = m0_datwr;
          s_we    = m0_we;
          s_stb   = m0_stb;
          s_cyc   = m0_cyc;
          s_sel   = m0_sel;
          m0_ack  = s_ack;
          if (!m0_cyc) begin
            w_next = m1_cyc ? GNT1 : IDLE;
          end
        end
      end
      GNT1: begin
        gnt = GNT_M1;
        if (w_expire) begin
          m1_ack   = 1'b1;
          m1_datrd = '1;
          w_next   = IDLE;
        end else begin
          s_adr   = m1_adr;
          s_datwr = m1_datwr;
          s_we    = m1_we;
          s_stb   = m1_stb;
          s_cyc   = m1_cyc;
          s_sel   = m1_sel;
          m1_ack  = s_ack;
          if (!m1_cyc) begin
            w_next = m0_cyc ? GNT0 : IDLE;
          end
        end
      end
      default: w_next = IDLE;
    endcase
  end

endmodule

// File: tb/tb_wishbone_arbiter.sv
// Directed bench for wishbone_arbiter: grant order, pass-through, async reset, watchdog.
module tb_wishbone_arbiter;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] m0_adr, m0_datwr, m0_sel, m0_datrd;
  logic       m0_we, m0_stb, m0_cyc, m0_ack;
  logic [7:0] m1_adr, m1_datwr, m1_sel, m1_datrd;
  logic       m1_we, m1_stb, m1_cyc, m1_ack;
  logic [7:0] s_adr, s_datwr, s_sel, s_datrd;
  logic       s_we, s_stb, s_cyc, s_ack;
  logic [1:0] gnt;
  logic       timeout;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  wishbone_arbiter #(
    .ADR_WIDTH(8), .DAT_WIDTH(8), .SEL_WIDTH(8), .TIMEOUT_CYCLES(4)
  ) dut (
    .clk(clk), .rst(rst),
    .m0_adr(m0_adr), .m0_datwr(m0_datwr), .m0_we(m0_we), .m0_stb(m0_stb),
    .m0_cyc(m0_cyc), .m0_sel(m0_sel), .m0_datrd(m0_datrd), .m0_ack(m0_ack),
    .m1_adr(m1_adr), .m1_datwr(m1_datwr), .m1_we(m1_we), .m1_stb(m1_stb),
    .m1_cyc(m1_cyc), .m1_sel(m1_sel), .m1_datrd(m1_datrd), .m1_ack(m1_ack),
    .s_adr(s_adr), .s_datwr(s_datwr), .s_we(s_we), .s_stb(s_stb),
    .s_cyc(s_cyc), .s_sel(s_sel), .s_datrd(s_datrd), .s_ack(s_ack),
    .gnt(gnt), .timeout(timeout)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0;
    m0_adr = '0; m0_datwr = '0; m0_we = 0; m0_stb = 0; m0_cyc = 0; m0_sel = '0;
    m1_adr = '0; m1_datwr = '0; m1_we = 0; m1_stb = 0; m1_cyc = 0; m1_sel = '0;
    s_datrd = '0; s_ack = 0;

    #12;
    chk("rst_gnt", gnt, 2'b00);
    chk("rst_scyc", s_cyc, 0);
    chk("rst_sstb", s_stb, 0);
    chk("rst_m0ack", m0_ack, 0);
    chk("rst_m1ack", m1_ack, 0);
    chk("rst_timeout", timeout, 0);
    tick();
    rst = 1'b1;

    // Single master read
    m0_cyc = 1; m0_stb = 1; m0_adr = 8'h12; m0_sel = 8'h01; m0_datwr = 8'h5A;
    #1;
    chk("t1_idle_gnt", gnt, 2'b00);
    chk("t1_idle_scyc", s_cyc, 0);
    chk("t1_idle_sadr", s_adr, 8'h00);
    tick();
    chk("t1_gnt", gnt, 2'b01);
    chk("t1_scyc", s_cyc, 1);
    chk("t1_sadr", s_adr, 8'h12);
    chk("t1_ssel", s_sel, 8'h01);
    s_ack = 1; s_datrd = 8'hA5;
    #1;
    chk("t1_m0ack", m0_ack, 1);
    chk("t1_m0datrd", m0_datrd, 8'hA5);
    chk("t1_m1ack", m1_ack, 0);
    tick();
    m0_cyc = 0; m0_stb = 0; s_ack = 0;
    tick();
    chk("t1_back_idle", gnt, 2'b00);

    // Fresh reset so the pointer favours m0 again
    rst = 1'b0;
    #2;
    rst = 1'b1;

    // Simultaneous request, then direct handover
    m0_cyc = 1; m0_stb = 1; m0_adr = 8'h12; m0_we = 0;
    m1_cyc = 1; m1_stb = 1; m1_adr = 8'h34; m1_we = 1; m1_datwr = 8'hC3;
    #1;
    chk("t2_idle_swe", s_we, 0);
    chk("t2_idle_sstb", s_stb, 0);
    tick();
    chk("t2_gnt_m0", gnt, 2'b01);
    chk("t2_sadr_m0", s_adr, 8'h12);
    s_ack = 1; s_datrd = 8'h11;
    #1;
    chk("t2_m0ack", m0_ack, 1);
    chk("t2_m1ack", m1_ack, 0);
    chk("t2_m1datrd_bcast", m1_datrd, 8'h11);
    tick();
    m0_cyc = 0; m0_stb = 0; s_ack = 0;
    #1;
    chk("t2_hold_m0", gnt, 2'b01);
    tick();
    chk("t2_gnt_m1", gnt, 2'b10);
    chk("t2_sadr_m1", s_adr, 8'h34);
    chk("t2_swe_m1", s_we, 1);
    chk("t2_sdatwr_m1", s_datwr, 8'hC3);

    // Fairness: alternate after each single-ack transaction
    s_ack = 1;
    #1;
    chk("t3_m1ack", m1_ack, 1);
    chk("t3_m0ack", m0_ack, 0);
    tick();
    m1_cyc = 0; m1_stb = 0; m0_cyc = 1; m0_stb = 1; s_ack = 0;
    tick();
    chk("t3_gnt3", gnt, 2'b01);
    m1_cyc = 1; m1_stb = 1;
    s_ack = 1;
    #1;
    chk("t3_m0ack3", m0_ack, 1);
    tick();
    m0_cyc = 0; m0_stb = 0; s_ack = 0;
    tick();
    chk("t3_gnt4", gnt, 2'b10);
    m1_cyc = 0; m1_stb = 0;
    tick();
    chk("t3_idle", gnt, 2'b00);

    // No preemption: m0 holds for three transfers while m1 waits
    m0_cyc = 1; m0_stb = 1;
    tick();
    chk("t4_gnt", gnt, 2'b01);
    m1_cyc = 1; m1_stb = 1;
    for (int i = 0; i < 3; i++) begin
      s_ack = 1;
      #1;
      chk("t4_hold_gnt", gnt, 2'b01);
      chk("t4_m0ack", m0_ack, 1);
      chk("t4_m1ack", m1_ack, 0);
      tick();
      s_ack = 0;
      #1;
      chk("t4_m1ack_wait", m1_ack, 0);
      tick();
      chk("t4_hold_gnt2", gnt, 2'b01);
    end
    m0_cyc = 0; m0_stb = 0;
    tick();
    chk("t4_gnt_m1", gnt, 2'b10);

    // Asynchronous reset in the middle of m1's access
    #2;
    rst = 1'b0;
    #1;
    chk("t5_gnt", gnt, 2'b00);
    chk("t5_scyc", s_cyc, 0);
    chk("t5_m1ack", m1_ack, 0);
    s_ack = 1;
    #1;
    chk("t5_m1ack_noack", m1_ack, 0);
    m1_cyc = 0; m1_stb = 0; s_ack = 0;
    rst = 1'b1;
    tick();
    chk("t5_idle", gnt, 2'b00);

    // Hung slave
    m0_cyc = 1; m0_stb = 1; s_ack = 0;
    tick();
    chk("t6_gnt", gnt, 2'b01);
`ifdef WB_ARB_TIMEOUT_EN
    repeat (3) tick();
    chk("t6_pre_timeout", timeout, 0);
    chk("t6_pre_m0ack", m0_ack, 0);
    tick();
    chk("t6_timeout", timeout, 1);
    chk("t6_m0ack", m0_ack, 1);
    chk("t6_m0datrd", m0_datrd, 8'hFF);
    chk("t6_scyc", s_cyc, 0);
    m0_cyc = 0; m0_stb = 0;
    tick();
    chk("t6_gnt_idle", gnt, 2'b00);
    chk("t6_timeout_clr", timeout, 0);
`else
    repeat (6) tick();
    chk("t6_hold_gnt", gnt, 2'b01);
    chk("t6_scyc", s_cyc, 1);
    chk("t6_timeout", timeout, 0);
    chk("t6_m0ack", m0_ack, 0);
    m0_cyc = 0; m0_stb = 0;
    tick();
    chk("t6_gnt_idle", gnt, 2'b00);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
